// File: rtl/branch_resolve_pkg.sv
// Shared constants and types for the branch resolution stage: RS geometry,
// operand width, the taken-bit position and the redirect/table record layouts.
package branch_resolve_pkg;

    localparam int RS_SIZE    = 4;
    localparam int RS_WIDTH   = 2;
    localparam int TAG_WIDTH  = 4;
    localparam int DATA_WIDTH = 32;
    localparam int TAKEN_BIT  = 0;

    localparam logic [TAG_WIDTH-1:0] tagFree = '0;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic                  taken;
    } redirect_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] imm;
    } pc_entry_t;

    // Modular 32-bit add; a wrapping target is a legal fetch address.
    function automatic logic [DATA_WIDTH-1:0] next_pc(input pc_entry_t e, input logic taken);
        return taken ? e.pc + e.imm : e.pc + DATA_WIDTH'(4);
    endfunction

endpackage

// File: rtl/redirect_fifo.sv
// Two-entry valid/ready queue of {PC, taken} redirects toward the Fetcher.
// Full is derived from the registered count only, so a pop never frees a slot for a same-cycle push.
module redirect_fifo
    import branch_resolve_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push_valid,
    input  redirect_t push_data,
    output logic      full,
    output logic      head_valid,
    output redirect_t head_data,
    input  logic      head_ready
);

    redirect_t  mem_reg [2];
    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic [1:0] count_next;
    logic       push;
    logic       pop;

    assign full       = (count_reg == 2'd2);
    assign head_valid = (count_reg != 2'd0);
    assign head_data  = mem_reg[rd_ptr_reg];
    assign push       = push_valid && !full;
    assign pop        = head_valid && head_ready;

    always_comb begin
        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + 2'd1;
        else if (pop && !push)
            count_next = count_reg - 2'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++)
                mem_reg[i] <= '0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution: per-slot {PC, imm} table, next-PC computation, RS-slot release
// and redirect queue. Optional taken/not-taken statistics under BRANCH_STAT_EN.
module branch_resolve
    import branch_resolve_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dispatchValid,
    input  logic [RS_WIDTH-1:0]   dispatchRSnum,
    input  logic [DATA_WIDTH-1:0] dispatchPC,
    input  logic [DATA_WIDTH-1:0] dispatchImm,
    input  logic                  branchALUSignal,
    input  logic [RS_WIDTH-1:0]   branchALU_CDB_out_RSnum,
    input  logic [TAG_WIDTH-1:0]  branchALU_CDB_out_tag,
    input  logic [DATA_WIDTH-1:0] branchALU_CDB_out_data,
    output logic                  resolveFull,
    output logic                  branchALUFinish,
    output logic [RS_WIDTH-1:0]   branchALU_CDB_RSnum,
    output logic                  redirectValid,
    output logic [DATA_WIDTH-1:0] redirectPC,
    output logic                  redirectTaken,
    input  logic                  fetchReady
`ifdef BRANCH_STAT_EN
    ,
    output logic [31:0]           statTaken,
    output logic [31:0]           statNotTaken
`endif
);

    pc_entry_t table_reg [RS_SIZE];
    pc_entry_t sel_entry;
    redirect_t push_data;
    redirect_t head_data;
    logic      capture;
    logic      taken;
    logic      unused_bits;

    assign unused_bits = ^{branchALU_CDB_out_tag, branchALU_CDB_out_data[DATA_WIDTH-1:1]};

    assign capture   = branchALUSignal && !resolveFull;
    assign taken     = branchALU_CDB_out_data[TAKEN_BIT];
    assign sel_entry = table_reg[branchALU_CDB_out_RSnum];
    assign push_data = '{pc: next_pc(sel_entry, taken), taken: taken};

    // The read above sees pre-edge contents, so a same-slot dispatch never bypasses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RS_SIZE; i++)
                table_reg[i] <= '0;
        end else if (dispatchValid) begin
            table_reg[dispatchRSnum] <= '{pc: dispatchPC, imm: dispatchImm};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branchALUFinish     <= 1'b0;
            branchALU_CDB_RSnum <= '0;
        end else begin
            branchALUFinish <= capture;
            if (capture)
                branchALU_CDB_RSnum <= branchALU_CDB_out_RSnum;
        end
    end

    redirect_fifo u_redirect_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (capture),
        .push_data  (push_data),
        .full       (resolveFull),
        .head_valid (redirectValid),
        .head_data  (head_data),
        .head_ready (fetchReady)
    );

    assign redirectPC    = head_data.pc;
    assign redirectTaken = head_data.taken;

`ifdef BRANCH_STAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            statTaken    <= '0;
            statNotTaken <= '0;
        end else if (capture) begin
            if (taken && statTaken != '1)
                statTaken <= statTaken + 32'd1;
            else if (!taken && statNotTaken != '1)
                statNotTaken <= statNotTaken + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: queue-based reference model checked every cycle,
// directed cases with literal expectations, then randomized traffic.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dispatchValid = 1'b0;
    logic [1:0]  dispatchRSnum = '0;
    logic [31:0] dispatchPC = '0;
    logic [31:0] dispatchImm = '0;
    logic        branchALUSignal = 1'b0;
    logic [1:0]  branchALU_CDB_out_RSnum = '0;
    logic [3:0]  branchALU_CDB_out_tag = '0;
    logic [31:0] branchALU_CDB_out_data = '0;
    logic        fetchReady = 1'b0;
    logic        resolveFull;
    logic        branchALUFinish;
    logic [1:0]  branchALU_CDB_RSnum;
    logic        redirectValid;
    logic [31:0] redirectPC;
    logic        redirectTaken;
`ifdef BRANCH_STAT_EN
    logic [31:0] statTaken;
    logic [31:0] statNotTaken;
`endif

    branch_resolve dut (
        .clk                     (clk),
        .rst                     (rst),
        .dispatchValid           (dispatchValid),
        .dispatchRSnum           (dispatchRSnum),
        .dispatchPC              (dispatchPC),
        .dispatchImm             (dispatchImm),
        .branchALUSignal         (branchALUSignal),
        .branchALU_CDB_out_RSnum (branchALU_CDB_out_RSnum),
        .branchALU_CDB_out_tag   (branchALU_CDB_out_tag),
        .branchALU_CDB_out_data  (branchALU_CDB_out_data),
        .resolveFull             (resolveFull),
        .branchALUFinish         (branchALUFinish),
        .branchALU_CDB_RSnum     (branchALU_CDB_RSnum),
        .redirectValid           (redirectValid),
        .redirectPC              (redirectPC),
        .redirectTaken           (redirectTaken),
        .fetchReady              (fetchReady)
`ifdef BRANCH_STAT_EN
        ,
        .statTaken               (statTaken),
        .statNotTaken            (statNotTaken)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue holds resolved redirects in order.
    typedef struct {
        logic [31:0] pc;
        logic        taken;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc [4];
    logic [31:0] m_imm [4];
    logic        m_fin;
    logic [1:0]  m_slot;
    ent_t        m_e;
    logic        m_acc;
    logic        m_pop;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_fin  = 1'b0;
            m_slot = 2'd0;
            for (int i = 0; i < 4; i++) begin
                m_pc[i]  = 32'd0;
                m_imm[i] = 32'd0;
            end
        end else begin
            m_acc = branchALUSignal && (q.size() < 2);
            m_pop = (q.size() > 0) && fetchReady;
            if (m_acc) begin
                m_e.taken = branchALU_CDB_out_data[0];
                m_e.pc    = m_e.taken ? m_pc[branchALU_CDB_out_RSnum] + m_imm[branchALU_CDB_out_RSnum]
                                      : m_pc[branchALU_CDB_out_RSnum] + 32'd4;
            end
            if (m_pop) void'(q.pop_front());
            if (m_acc) q.push_back(m_e);
            m_fin = m_acc;
            if (m_acc) m_slot = branchALU_CDB_out_RSnum;
            if (dispatchValid) begin
                m_pc[dispatchRSnum]  = dispatchPC;
                m_imm[dispatchRSnum] = dispatchImm;
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("cmp_full",   32'(resolveFull),     32'(q.size() == 2));
            chk("cmp_valid",  32'(redirectValid),   32'(q.size() != 0));
            chk("cmp_finish", 32'(branchALUFinish), 32'(m_fin));
            chk("cmp_rsnum",  32'(branchALU_CDB_RSnum), 32'(m_slot));
            if (q.size() != 0) begin
                chk("cmp_pc",    redirectPC,         q[0].pc);
                chk("cmp_taken", 32'(redirectTaken), 32'(q[0].taken));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dispatchValid   = 1'b0;
        branchALUSignal = 1'b0;
    endtask

    task automatic dispatch(input logic [1:0] s, input logic [31:0] pc, input logic [31:0] imm);
        dispatchValid = 1'b1;
        dispatchRSnum = s;
        dispatchPC    = pc;
        dispatchImm   = imm;
    endtask

    task automatic result(input logic [1:0] s, input logic [31:0] d);
        branchALUSignal         = 1'b1;
        branchALU_CDB_out_RSnum = s;
        branchALU_CDB_out_data  = d;
        branchALU_CDB_out_tag   = 4'(s) + 4'd3;
    endtask

    initial begin
        // Reset held, then idle.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid",  32'(redirectValid),   32'd0);
        chk("rst_pc",     redirectPC,           32'd0);
        chk("rst_full",   32'(resolveFull),     32'd0);
        chk("rst_finish", 32'(branchALUFinish), 32'd0);
        rst = 1'b1;
        cyc();
        cyc();
        chk("idle_valid", 32'(redirectValid), 32'd0);
        chk("idle_rsnum", 32'(branchALU_CDB_RSnum), 32'd0);

        // Taken branch: 0x100 + 0x20.
        fetchReady = 1'b1;
        dispatch(2'd2, 32'h100, 32'h20);
        cyc();
        idle();
        result(2'd2, 32'h1);
        cyc();
        idle();
        chk("t1_pc",       redirectPC,                32'h120);
        chk("t1_taken",    32'(redirectTaken),        32'd1);
        chk("t1_finish",   32'(branchALUFinish),      32'd1);
        chk("t1_rsnum",    32'(branchALU_CDB_RSnum),  32'd2);
        chk("t1_model_pc", q.size() != 0 ? q[0].pc : 32'hDEAD, 32'h120);
        cyc();
        chk("t1_popped",   32'(redirectValid),        32'd0);
        chk("t1_fin_low",  32'(branchALUFinish),      32'd0);

        // Not taken with negative offset: falls through to PC+4.
        dispatch(2'd1, 32'h200, 32'hFFFF_FFF8);
        cyc();
        idle();
        result(2'd1, 32'hFFFF_FFFE);
        cyc();
        idle();
        chk("t2_pc",    redirectPC,         32'h204);
        chk("t2_taken", 32'(redirectTaken), 32'd0);
        cyc();

        // Back-pressure: third result is dropped while full.
        fetchReady = 1'b0;
        result(2'd2, 32'h1);
        cyc();
        result(2'd1, 32'h0);
        cyc();
        chk("t3_full",    32'(resolveFull), 32'd1);
        result(2'd2, 32'h1);
        cyc();
        idle();
        chk("t3_drop_fin", 32'(branchALUFinish), 32'd0);
        chk("t3_head0",    redirectPC,           32'h120);
        cyc();
        chk("t3_stable",   redirectPC,           32'h120);
        fetchReady = 1'b1;
        cyc();
        chk("t3_head1",    redirectPC,           32'h204);
        chk("t3_notfull",  32'(resolveFull),     32'd0);
        cyc();
        chk("t3_empty",    32'(redirectValid),   32'd0);

        // Address wrap.
        dispatch(2'd3, 32'hFFFF_FFFC, 32'h8);
        cyc();
        idle();
        result(2'd3, 32'h1);
        cyc();
        idle();
        chk("t4_wrap", redirectPC, 32'h4);
        cyc();

        // Async reset with two queued redirects.
        fetchReady = 1'b0;
        result(2'd3, 32'h1);
        cyc();
        result(2'd2, 32'h0);
        cyc();
        idle();
        #2 rst = 1'b0;
        #1;
        chk("t5_valid",  32'(redirectValid),   32'd0);
        chk("t5_full",   32'(resolveFull),     32'd0);
        chk("t5_finish", 32'(branchALUFinish), 32'd0);
        #2 rst = 1'b1;
        fetchReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t5_no_fin", 32'(branchALUFinish), 32'd0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            dispatchValid = 1'($urandom_range(0, 1));
            dispatchRSnum = 2'($urandom_range(0, 3));
            dispatchPC    = $urandom & 32'hFFFF_FFFC;
            dispatchImm   = ($urandom_range(0, 3) == 0) ? $urandom
                                                        : 32'($signed(13'($urandom_range(0, 8191))));
            branchALUSignal         = ($urandom_range(0, 3) != 0);
            branchALU_CDB_out_RSnum = 2'($urandom_range(0, 3));
            branchALU_CDB_out_tag   = 4'($urandom_range(0, 15));
            branchALU_CDB_out_data  = $urandom;
            fetchReady              = ($urandom_range(0, 2) != 0);
            cyc();
        end
        idle();
        fetchReady = 1'b1;
        repeat (4) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
